// File: rtl/valid_strobe_gen.sv
// Programmable-period strobe generator: one-cycle o_valid pulse every LIMIT_R[i_sel] clocks while running.
// Optional macro VALID_STROBE_SYNC_INPUTS_EN adds 2-flop synchronizers on i_enable, i_clear and i_sel.
module valid_strobe_gen #(
  parameter int          NB_COUNTER = 32,
  parameter int unsigned LIMIT_R0   = 2**14,
  parameter int unsigned LIMIT_R1   = 2**16,
  parameter int unsigned LIMIT_R2   = 2**18,
  parameter int unsigned LIMIT_R3   = 2**20
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic [1:0] i_sel,
  output logic       o_valid,
  output logic       o_running
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [NB_COUNTER-1:0] LIM_M1_R0 = NB_COUNTER'(LIMIT_R0 - 1);
  localparam logic [NB_COUNTER-1:0] LIM_M1_R1 = NB_COUNTER'(LIMIT_R1 - 1);
  localparam logic [NB_COUNTER-1:0] LIM_M1_R2 = NB_COUNTER'(LIMIT_R2 - 1);
  localparam logic [NB_COUNTER-1:0] LIM_M1_R3 = NB_COUNTER'(LIMIT_R3 - 1);

  logic                  enable;
  logic                  clear;
  logic [1:0]            sel;
  state_t                state;
  state_t                state_next;
  logic [NB_COUNTER-1:0] count;
  logic [NB_COUNTER-1:0] count_next;
  logic [NB_COUNTER-1:0] lim_m1;
  logic                  valid_next;

`ifdef VALID_STROBE_SYNC_INPUTS_EN
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {i_sel, i_clear, i_enable};
      sync_q2 <= sync_q1;
    end
  end

  assign enable = sync_q2[0];
  assign clear  = sync_q2[1];
  assign sel    = sync_q2[3:2];
`else
  assign enable = i_enable;
  assign clear  = i_clear;
  assign sel    = i_sel;
`endif

  always_comb begin
    lim_m1 = LIM_M1_R0;
    case (sel)
      2'd0:    lim_m1 = LIM_M1_R0;
      2'd1:    lim_m1 = LIM_M1_R1;
      2'd2:    lim_m1 = LIM_M1_R2;
      default: lim_m1 = LIM_M1_R3;
    endcase
  end

  // The counter steps on every edge whose next state is RUN, including the entering edge,
  // so the first pulse lands in cycle lim of the run.
  always_comb begin
    state_next = state;
    count_next = count;
    valid_next = 1'b0;
    if (clear) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE:    if (enable)  state_next = RUN;
        RUN:     if (!enable) state_next = HOLD;
        HOLD:    if (enable)  state_next = RUN;
        default: state_next = IDLE;
      endcase
      if (state_next == RUN) begin
        if (count >= lim_m1) begin
          count_next = '0;
          valid_next = 1'b1;
        end else begin
          count_next = count + NB_COUNTER'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      count     <= '0;
      o_valid   <= 1'b0;
      o_running <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      o_valid   <= valid_next;
      o_running <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_valid_strobe_gen.sv
// Directed self-checking bench for valid_strobe_gen with small limits (4, 6, 8, 3) and an 8-bit counter.
// Cycle n is the interval just after rising edge n; outputs are sampled 1 time unit after each edge.
module tb_valid_strobe_gen;

`ifdef VALID_STROBE_SYNC_INPUTS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clock;
  logic       i_reset;
  logic       i_enable;
  logic       i_clear;
  logic [1:0] i_sel;
  logic       o_valid;
  logic       o_running;

  int checks = 0;
  int errors = 0;

  valid_strobe_gen #(
    .NB_COUNTER(8),
    .LIMIT_R0(4),
    .LIMIT_R1(6),
    .LIMIT_R2(8),
    .LIMIT_R3(3)
  ) dut (
    .clock(clock),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_clear(i_clear),
    .i_sel(i_sel),
    .o_valid(o_valid),
    .o_running(o_running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic en, input logic clr, input logic [1:0] sel);
    i_enable = en;
    i_clear  = clr;
    i_sel    = sel;
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int cyc, input logic exp_valid, input logic exp_running);
    checks++;
    assert (o_valid === exp_valid) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d o_valid: got %b expected %b", tag, cyc, o_valid, exp_valid);
    end
    checks++;
    assert (o_running === exp_running) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d o_running: got %b expected %b", tag, cyc, o_running, exp_running);
    end
  endtask

  initial begin
    i_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'd0);
    waitCycle();
    waitCycle();
    checkOutput("reset", 0, 1'b0, 1'b0);

    // Test 1: free run at period 4, pulses at cycles 4, 8, 12 (shifted by LAT with synchronizers)
    $display("[TB] test 1: free run, sel=0");
    i_reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int c = 1; c <= 13 + LAT; c++) begin
      waitCycle();
      checkOutput("t1_run", c, (c > LAT) && (((c - LAT) % 4) == 0), c >= 1 + LAT);
    end

`ifndef VALID_STROBE_SYNC_INPUTS_EN
    applyStimulus(1'b0, 1'b1, 2'd0);
    waitCycle();
    checkOutput("clear_idle", 0, 1'b0, 1'b0);

    // Test 2: run 2, hold 5, resume; frozen count 2 means the pulse lands on the 2nd resumed edge
    $display("[TB] test 2: hold and resume");
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int c = 1; c <= 2; c++) begin
      waitCycle();
      checkOutput("t2_run", c, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 2'd0);
    for (int c = 3; c <= 7; c++) begin
      waitCycle();
      checkOutput("t2_hold", c, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int c = 8; c <= 13; c++) begin
      waitCycle();
      checkOutput("t2_resume", c, (c == 9) || (c == 13), 1'b1);
    end

    applyStimulus(1'b0, 1'b1, 2'd2);
    waitCycle();
    checkOutput("clear_idle", 0, 1'b0, 1'b0);

    // Test 3: count reaches 5 at period 8, then switch to period 3 -> immediate pulse, then every 3
    $display("[TB] test 3: period switch mid-count");
    applyStimulus(1'b1, 1'b0, 2'd2);
    for (int c = 1; c <= 5; c++) begin
      waitCycle();
      checkOutput("t3_sel2", c, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 2'd3);
    for (int c = 1; c <= 7; c++) begin
      waitCycle();
      checkOutput("t3_sel3", c, (c == 1) || (c == 4) || (c == 7), 1'b1);
    end

    applyStimulus(1'b0, 1'b1, 2'd0);
    waitCycle();
    checkOutput("clear_idle", 0, 1'b0, 1'b0);

    // Test 4: clear with enable on the edge that would otherwise pulse
    $display("[TB] test 4: clear beats enable");
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int c = 1; c <= 3; c++) begin
      waitCycle();
      checkOutput("t4_run", c, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b1, 2'd0);
    waitCycle();
    checkOutput("t4_clear", 4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int c = 1; c <= 4; c++) begin
      waitCycle();
      checkOutput("t4_restart", c, c == 4, 1'b1);
    end

    // Test 5: asynchronous reset between edges, first during a pulse, then mid-count
    $display("[TB] test 5: async reset");
    #3;
    i_reset = 1'b0;
    #1;
    checkOutput("t5_async_pulse", 0, 1'b0, 1'b0);
    waitCycle();
    checkOutput("t5_in_reset", 0, 1'b0, 1'b0);
    i_reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int c = 1; c <= 2; c++) begin
      waitCycle();
      checkOutput("t5_run", c, 1'b0, 1'b1);
    end
    #3;
    i_reset = 1'b0;
    #1;
    checkOutput("t5_async_count", 0, 1'b0, 1'b0);
    waitCycle();
    i_reset = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      waitCycle();
      checkOutput("t5_restart", c, c == 4, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
